// File: rtl/argon_bus_pkg.sv
// Shared types for the argon CPU bus fabric.
// Arbiter states, grant indices and the request bundle.
package argon_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_GRANT_IF  = 2'd1,
    ARB_GRANT_LSU = 2'd2
  } arb_state_t;

  localparam int GRANT_IF  = 0;
  localparam int GRANT_LSU = 1;

  localparam int WB_TIMEOUT_CYCLES = 255;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  function automatic logic [1:0] grant_vec(
    input arb_state_t s
  );
    logic [1:0] g;
    g = 2'b00;
    g[GRANT_IF]  = (s == ARB_GRANT_IF);
    g[GRANT_LSU] = (s == ARB_GRANT_LSU);
    return g;
  endfunction

endpackage

// File: rtl/wishbone_if.sv
// 32-bit classic Wishbone link between one master and one slave.
// Master drives the request side, slave drives ack and read data.
interface wishbone_if;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_mosi;
  logic [31:0] dat_miso;
  logic        ack;

  modport master (
    output cyc, stb, we, sel, adr, dat_mosi,
    input  dat_miso, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_mosi,
    output dat_miso, ack
  );

endinterface

// File: rtl/wb_bus_watchdog.sv
// Per-transfer stall counter for the shared Wishbone bus.
// Fires expire on the last allowed stalled cycle.
module wb_bus_watchdog
  import argon_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic stb,
  input  logic ack,
  output logic expire
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] LAST =
    CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;
  logic          stall;

  assign stall  = enable & stb & ~ack;
  assign expire = EN & stall & (count == LAST);

  // any ack, idle beat or grant release restarts the window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (stall && !expire) begin
      count <= count + 1'b1;
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/wishbone_arbiter_2to1.sv
// Merges the CPU fetch and load/store Wishbone masters onto one bus.
// Grants are registered and held for a whole cyc; a watchdog ends stalls.
module wishbone_arbiter_2to1
  import argon_bus_pkg::*;
#(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  wishbone_if.slave  if_bus,
  wishbone_if.slave  lsu_bus,
  wishbone_if.master mem_bus,
  output logic [1:0] o_grant,
  output logic       o_timeout
);

  localparam bit RR_EN = (ROUND_ROBIN != 0);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       prio_lsu;
  logic       prio_nxt;

  wb_req_t if_req;
  wb_req_t lsu_req;
  wb_req_t sel_req;

  logic req_if;
  logic req_lsu;
  logic gnt_if;
  logic gnt_lsu;
  logic expire;

  assign if_req = {
    if_bus.cyc, if_bus.stb, if_bus.we,
    if_bus.sel, if_bus.adr, if_bus.dat_mosi
  };
  assign lsu_req = {
    lsu_bus.cyc, lsu_bus.stb, lsu_bus.we,
    lsu_bus.sel, lsu_bus.adr, lsu_bus.dat_mosi
  };

  assign req_if  = if_bus.cyc & if_bus.stb;
  assign req_lsu = lsu_bus.cyc & lsu_bus.stb;

  assign gnt_if  = (state == ARB_GRANT_IF);
  assign gnt_lsu = (state == ARB_GRANT_LSU);

  always_comb begin
    sel_req = '0;
    unique case (1'b1)
      gnt_if:  sel_req = if_req;
      gnt_lsu: sel_req = lsu_req;
      default: sel_req = '0;
    endcase
  end

  wb_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .enable (gnt_if | gnt_lsu),
    .stb    (sel_req.stb),
    .ack    (mem_bus.ack),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ARB_IDLE;
      prio_lsu <= 1'b1;
    end else begin
      state    <= state_nxt;
      prio_lsu <= prio_nxt;
    end
  end

  // prio_lsu marks which master wins the next tie
  always_comb begin
    state_nxt = state;
    prio_nxt  = prio_lsu;
    unique case (state)
      ARB_IDLE: begin
        if (req_lsu &&
            (!req_if || !RR_EN || prio_lsu)) begin
          state_nxt = ARB_GRANT_LSU;
          prio_nxt  = 1'b0;
        end else if (req_if) begin
          state_nxt = ARB_GRANT_IF;
          prio_nxt  = 1'b1;
        end
      end
      ARB_GRANT_IF: begin
        if (!if_bus.cyc || expire) begin
          state_nxt = ARB_IDLE;
        end
      end
      ARB_GRANT_LSU: begin
        if (!lsu_bus.cyc || expire) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign mem_bus.cyc      = sel_req.cyc & ~expire;
  assign mem_bus.stb      = sel_req.stb & ~expire;
  assign mem_bus.we       = sel_req.we;
  assign mem_bus.sel      = sel_req.sel;
  assign mem_bus.adr      = sel_req.adr;
  assign mem_bus.dat_mosi = sel_req.dat;

  // a watchdog kill answers the master with a zero-data ack
  assign if_bus.ack  = gnt_if & (mem_bus.ack | expire);
  assign lsu_bus.ack = gnt_lsu & (mem_bus.ack | expire);

  assign if_bus.dat_miso =
    (gnt_if & ~expire) ? mem_bus.dat_miso : '0;
  assign lsu_bus.dat_miso =
    (gnt_lsu & ~expire) ? mem_bus.dat_miso : '0;

  assign o_grant   = grant_vec(state);
  assign o_timeout = expire;

endmodule

// File: tb/tb_wishbone_arbiter_2to1.sv
// Bench for wishbone_arbiter_2to1: round-robin and fixed-priority
// instances side by side, scoreboarded against an owner-level model.
module tb_wishbone_arbiter_2to1;

  localparam int TO = 8;
  localparam logic [31:0] SALT = 32'h5A5A_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        m_cyc [2][2];
  logic        m_stb [2][2];
  logic        m_we  [2][2];
  logic [3:0]  m_sel [2][2];
  logic [31:0] m_adr [2][2];
  logic [31:0] m_dat [2][2];
  logic        m_ack [2][2];
  logic [31:0] m_rd  [2][2];

  logic        b_cyc [2];
  logic        b_stb [2];
  logic        b_we  [2];
  logic [3:0]  b_sel [2];
  logic [31:0] b_adr [2];
  logic [31:0] b_dat [2];

  logic [1:0]  grant [2];
  logic        tmo   [2];
  logic        s_ack [2];
  logic        hang  [2];
  logic [1:0]  fix_ws [2];
  logic        rand_ws;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } exp_t;

  exp_t q [2][2][$];

  int own   [2];
  int last  [2];
  int stall [2];

  for (genvar g = 0; g < 2; g++) begin : u
    wishbone_if ifb ();
    wishbone_if lsb ();
    wishbone_if mem ();
    logic [1:0] wcnt;
    logic [1:0] ws_r;
    logic       sstb;

    assign ifb.cyc      = m_cyc[g][0];
    assign ifb.stb      = m_stb[g][0];
    assign ifb.we       = m_we[g][0];
    assign ifb.sel      = m_sel[g][0];
    assign ifb.adr      = m_adr[g][0];
    assign ifb.dat_mosi = m_dat[g][0];
    assign lsb.cyc      = m_cyc[g][1];
    assign lsb.stb      = m_stb[g][1];
    assign lsb.we       = m_we[g][1];
    assign lsb.sel      = m_sel[g][1];
    assign lsb.adr      = m_adr[g][1];
    assign lsb.dat_mosi = m_dat[g][1];

    assign m_ack[g][0] = ifb.ack;
    assign m_rd[g][0]  = ifb.dat_miso;
    assign m_ack[g][1] = lsb.ack;
    assign m_rd[g][1]  = lsb.dat_miso;

    assign b_cyc[g] = mem.cyc;
    assign b_stb[g] = mem.stb;
    assign b_we[g]  = mem.we;
    assign b_sel[g] = mem.sel;
    assign b_adr[g] = mem.adr;
    assign b_dat[g] = mem.dat_mosi;

    // slave model: ack after a number of wait states
    assign sstb = (grant[g][0] & m_stb[g][0]) |
                  (grant[g][1] & m_stb[g][1]);
    assign s_ack[g] = sstb & ~hang[g] &
      (wcnt == (rand_ws ? ws_r : fix_ws[g]));
    assign mem.ack      = s_ack[g];
    assign mem.dat_miso = mem.adr ^ SALT;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wcnt <= 2'd0;
        ws_r <= 2'd0;
      end else if (sstb && !s_ack[g]) begin
        wcnt <= wcnt + 2'd1;
      end else begin
        wcnt <= 2'd0;
        if (s_ack[g]) ws_r <= 2'($urandom_range(0, 3));
      end
    end

    wishbone_arbiter_2to1 #(
      .ROUND_ROBIN    ((g == 0) ? 1 : 0),
      .TIMEOUT_CYCLES (TO)
    ) dut (
      .clk       (clk),
      .reset     (rst_n),
      .if_bus    (ifb),
      .lsu_bus   (lsb),
      .mem_bus   (mem),
      .o_grant   (grant[g]),
      .o_timeout (tmo[g])
    );
  end

  task automatic chk(input string nm, input int g,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h want %0h at %0t",
               nm, g, act, exp, $time);
    end
  endtask

  // owner-level reference: who holds the bus, and for how long
  task automatic monitor(input int g);
    bit         to_e;
    bit         mine;
    bit         r0;
    bit         r1;
    int         o;
    logic [1:0] eg;
    exp_t       e;
    if (!rst_n) begin
      own[g]   = -1;
      last[g]  = 0;
      stall[g] = 0;
      q[g][0].delete();
      q[g][1].delete();
      chk("rst_grant", g, grant[g], 0);
      chk("rst_bus", g, {b_cyc[g], b_stb[g]}, 0);
      chk("rst_ack", g, {m_ack[g][0], m_ack[g][1]}, 0);
      chk("rst_timeout", g, tmo[g], 0);
      return;
    end
    o    = own[g];
    to_e = (o >= 0) && m_stb[g][o] && !s_ack[g] &&
           (stall[g] == TO - 1);
    eg   = (o < 0) ? 2'b00 : (2'b01 << o);
    chk("grant", g, grant[g], eg);
    chk("timeout", g, tmo[g], to_e);
    if (o < 0) begin
      chk("idle_bus", g,
          {b_cyc[g], b_stb[g], b_we[g], b_sel[g],
           b_adr[g], b_dat[g]}, 0);
    end else begin
      chk("bus_ctl", g, {b_cyc[g], b_stb[g]},
          {m_cyc[g][o] & !to_e, m_stb[g][o] & !to_e});
      if (!to_e)
        chk("bus_fields", g,
            {b_we[g], b_sel[g], b_adr[g], b_dat[g]},
            {m_we[g][o], m_sel[g][o], m_adr[g][o], m_dat[g][o]});
    end
    for (int m = 0; m < 2; m++) begin
      mine = (o == m);
      chk(m ? "ack_lsu" : "ack_if", g, m_ack[g][m],
          mine && (s_ack[g] || to_e));
      if (!mine) chk("miso_zero", g, m_rd[g][m], 0);
      if (m_ack[g][m]) begin
        if (q[g][m].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty inst%0d master%0d at %0t",
                   g, m, $time);
        end else begin
          e = q[g][m].pop_front();
          if (to_e || !e.we)
            chk("rdata", g, m_rd[g][m], to_e ? 32'h0 : e.data);
        end
      end
    end
    if (o >= 0) begin
      stall[g] = (m_stb[g][o] && !s_ack[g] && !to_e) ?
                 stall[g] + 1 : 0;
      if (to_e || !m_cyc[g][o]) own[g] = -1;
    end else begin
      r0 = m_cyc[g][0] && m_stb[g][0];
      r1 = m_cyc[g][1] && m_stb[g][1];
      if (r0 || r1) begin
        if (r0 && r1) own[g] = (g == 0) ? 1 - last[g] : 1;
        else          own[g] = r1 ? 1 : 0;
        last[g]  = own[g];
        stall[g] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    monitor(0);
    monitor(1);
  end

  task automatic xfer(input int g, input int m, input int beats,
                      input logic we, input logic [31:0] adr,
                      input logic [3:0] sel, input logic [31:0] dat);
    int n;
    m_cyc[g][m] = 1'b1;
    m_we[g][m]  = we;
    m_sel[g][m] = sel;
    for (int b = 0; b < beats; b++) begin
      m_adr[g][m] = adr + 32'(b * 4);
      m_dat[g][m] = dat + 32'(b);
      m_stb[g][m] = 1'b1;
      q[g][m].push_back('{we, m_adr[g][m] ^ SALT});
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!m_ack[g][m] && rst_n && n < 400);
      if (!rst_n) begin
        m_cyc[g][m] = 1'b0;
        m_stb[g][m] = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      chk("ack_wait", g, m_ack[g][m], 1'b1);
      @(posedge clk);
      #1;
      m_stb[g][m] = 1'b0;
      if (b < beats - 1) begin
        @(posedge clk);
        #1;
      end
    end
    m_cyc[g][m] = 1'b0;
  endtask

  task automatic rand_master(input int g, input int m, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      xfer(g, m, int'($urandom_range(1, 2)),
           1'($urandom_range(0, 1)),
           $urandom & 32'hFFFF_FFFC,
           4'($urandom_range(1, 15)), $urandom);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    rand_ws = 1'b0;
    for (int g = 0; g < 2; g++) begin
      hang[g]   = 1'b0;
      fix_ws[g] = 2'd0;
      own[g]    = -1;
      last[g]   = 0;
      stall[g]  = 0;
      for (int m = 0; m < 2; m++) begin
        m_cyc[g][m] = 1'b0;
        m_stb[g][m] = 1'b0;
        m_we[g][m]  = 1'b0;
        m_sel[g][m] = 4'h0;
        m_adr[g][m] = 32'h0;
        m_dat[g][m] = 32'h0;
      end
    end
    step(3);
    rst_n = 1'b1;
    step(1);

    // IF single read, zero-wait slave
    for (int g = 0; g < 2; g++) begin
      automatic int gg = g;
      fork
        xfer(gg, 0, 1, 1'b0, 32'h90A4_0013, 4'hF, 32'h0);
      join_none
    end
    wait fork;
    step(2);

    // simultaneous requests, six transfers each
    for (int g = 0; g < 2; g++) begin
      automatic int gg = g;
      fork
        begin
          for (int i = 0; i < 6; i++)
            xfer(gg, 0, 1, 1'b0, 32'h100 + 32'(i * 4), 4'hF, 0);
        end
        begin
          for (int i = 0; i < 6; i++)
            xfer(gg, 1, 1, 1'b0, 32'h200 + 32'(i * 4), 4'hF, 0);
        end
      join_none
    end
    wait fork;
    step(2);

    // LSU write, three wait states
    for (int g = 0; g < 2; g++) fix_ws[g] = 2'd3;
    for (int g = 0; g < 2; g++) begin
      automatic int gg = g;
      fork
        xfer(gg, 1, 1, 1'b1, 32'h0000_1004, 4'b0011, 32'h0000_BEEF);
      join_none
    end
    wait fork;
    step(2);

    // slave hangs: watchdog ends the LSU read, IF waits
    for (int g = 0; g < 2; g++) begin
      fix_ws[g] = 2'd0;
      hang[g]   = 1'b1;
    end
    for (int g = 0; g < 2; g++) begin
      automatic int gg = g;
      fork
        begin
          xfer(gg, 1, 1, 1'b0, 32'h0000_2000, 4'hF, 0);
          hang[gg] = 1'b0;
        end
        begin
          step(2);
          xfer(gg, 0, 1, 1'b0, 32'h0000_3000, 4'hF, 0);
        end
      join_none
    end
    wait fork;
    step(2);

    // reset in the middle of a two-wait-state read
    for (int g = 0; g < 2; g++) fix_ws[g] = 2'd2;
    for (int g = 0; g < 2; g++) begin
      automatic int gg = g;
      fork
        xfer(gg, 1, 1, 1'b0, 32'h0000_4000, 4'hF, 0);
      join_none
    end
    step(2);
    rst_n = 1'b0;
    wait fork;
    step(1);
    rst_n = 1'b1;
    step(1);

    // randomized contention with multi-beat cycles
    rand_ws = 1'b1;
    for (int g = 0; g < 2; g++) begin
      automatic int gg = g;
      fork
        rand_master(gg, 0, 12);
        rand_master(gg, 1, 12);
      join_none
    end
    wait fork;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
